store_capture_ctrl: RTL and testbench

Harness-side controller for the single-cycle ARM core. It raises the core's start input on request and monitors the data-memory store bus (MemWrite/DataAdr/WriteData). Stores to a configured window are queued in a FIFO and drained over a valid/ready stream. A store to the completion address ends the run with a pass/fail verdict. It is the consumer end of the core's store traffic, so runs can be checked without a testbench peeking at internal signals.

---
 rtl/store_capture_ctrl.sv | 130 +++++++++++++
 tb/tb_store_capture_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/store_capture_ctrl.sv
// rtl/store_capture_ctrl.sv - harness-side run controller and store-capture FIFO for the core
// Starts a run, queues windowed stores, and reports a pass/fail verdict on the done store.
module store_capture_ctrl #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] CAP_BASE   = 32'h0000_0040,
  parameter int          CAP_WORDS  = 16,
  parameter logic [31:0] DONE_ADDR  = 32'h0000_0064,
  parameter logic [31:0] PASS_VALUE = 32'h0000_0007,
  parameter int          TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  output logic        start,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        pass,
  output logic        overflow,
  output logic        timeout
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] CAP_END  = {1'b0, CAP_BASE} + 33'(4 * CAP_WORDS);
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic        ovf_q, ovf_d;
  logic        tmo_q, tmo_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [63:0] mem_q [DEPTH];

  logic [AW:0] count;
  logic        empty, full, in_win, is_done, capture, pop, push;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign in_win  = (DataAdr[1:0] == 2'b00) && (DataAdr >= CAP_BASE)
                   && ({1'b0, DataAdr} < CAP_END);
  assign is_done = (DataAdr == DONE_ADDR);
  assign capture = (state_q == S_RUN) && MemWrite && (in_win || is_done);
  assign pop     = !empty && rd_ready;
  assign push    = capture && (!full || pop);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (go) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        // A done store in the final counted cycle beats the timeout.
        if (MemWrite && is_done) begin
          pass_d  = (WriteData == PASS_VALUE);
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture && full && !pop) ovf_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q[AW-1:0]] <= {DataAdr, WriteData};
  end

  assign start    = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign rd_valid = !empty;
  assign rd_addr  = mem_q[rd_ptr_q[AW-1:0]][63:32];
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]][31:0];
  assign pass     = pass_q;
  assign overflow = ovf_q;
  assign timeout  = tmo_q;

endmodule

// File: tb/tb_store_capture_ctrl.sv
// tb/tb_store_capture_ctrl.sv - directed self-checking bench for store_capture_ctrl
module tb_store_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset, go, MemWrite, rd_ready;
  logic [31:0] DataAdr, WriteData;

  logic        start, rd_valid, done, pass, overflow, timeout;
  logic [31:0] rd_addr, rd_data;
  logic        start_t, rd_valid_t, done_t, pass_t, overflow_t, timeout_t;
  logic [31:0] rd_addr_t, rd_data_t;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  store_capture_ctrl dut (
    .clk(clk), .reset(reset), .go(go), .start(start),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .pass(pass), .overflow(overflow), .timeout(timeout)
  );

  store_capture_ctrl #(.TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .go(go), .start(start_t),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .rd_valid(rd_valid_t), .rd_ready(rd_ready), .rd_addr(rd_addr_t), .rd_data(rd_data_t),
    .done(done_t), .pass(pass_t), .overflow(overflow_t), .timeout(timeout_t)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
  endtask

  task automatic idle_bus();
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic new_run();
    reset = 1'b1; go = 1'b0; idle_bus();
    tick();
    reset = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  logic [31:0] exp_a [8];
  logic [31:0] exp_d [8];

  initial begin
    reset = 1'b1; go = 1'b0; rd_ready = 1'b0;
    idle_bus();

    // Reset held two cycles, go sampled on the third.
    tick();
    tick();
    check("reset_start", {63'd0, start}, 64'd0);
    check("reset_flags", {58'd0, rd_valid, done, pass, overflow, timeout, 1'b0}, 64'd0);
    reset = 1'b0; go = 1'b1;
    tick();
    check("go_start", {63'd0, start}, 64'd1);
    go = 1'b0;

    // Windowed capture streams out one cycle after each store.
    rd_ready = 1'b1;
    store(32'h40, 32'hA);
    tick();
    check("cap0_valid", {63'd0, rd_valid}, 64'd1);
    check("cap0_head", {rd_addr, rd_data}, {32'h40, 32'hA});
    store(32'h44, 32'hB);
    tick();
    check("cap1_valid", {63'd0, rd_valid}, 64'd1);
    check("cap1_head", {rd_addr, rd_data}, {32'h44, 32'hB});
    store(32'h100, 32'hC);
    tick();
    check("outwin_empty", {63'd0, rd_valid}, 64'd0);
    store(32'h42, 32'hD);
    tick();
    check("misalign_empty", {63'd0, rd_valid}, 64'd0);

    // Fill to DEPTH with the consumer stalled.
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      store(32'h40 + 32'(4 * i), 32'h100 + 32'(i));
      tick();
    end
    check("full_no_ovf", {63'd0, overflow}, 64'd0);
    check("full_head", {rd_addr, rd_data}, {32'h40, 32'h100});

    // Push with simultaneous pop while full is accepted.
    rd_ready = 1'b1;
    store(32'h7C, 32'h1FF);
    tick();
    check("pushpop_ovf", {63'd0, overflow}, 64'd0);
    check("pushpop_head", {rd_addr, rd_data}, {32'h44, 32'h101});

    // Push while full without pop is dropped.
    rd_ready = 1'b0;
    store(32'h78, 32'h1EE);
    tick();
    check("drop_ovf", {63'd0, overflow}, 64'd1);
    check("drop_head", {rd_addr, rd_data}, {32'h44, 32'h101});

    for (int k = 0; k < 7; k++) begin
      exp_a[k] = 32'h44 + 32'(4 * k);
      exp_d[k] = 32'h101 + 32'(k);
    end
    exp_a[7] = 32'h7C;
    exp_d[7] = 32'h1FF;
    idle_bus();
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d_valid", k), {63'd0, rd_valid}, 64'd1);
      check($sformatf("drain%0d_head", k), {rd_addr, rd_data}, {exp_a[k], exp_d[k]});
      tick();
    end
    check("drained_empty", {63'd0, rd_valid}, 64'd0);

    // Passing done store; a store during DRAIN must not be queued.
    rd_ready = 1'b0;
    store(32'h64, 32'h7);
    tick();
    check("done_start_low", {63'd0, start}, 64'd0);
    check("done_entry", {rd_addr, rd_data}, {32'h64, 32'h7});
    check("done_pass_early", {62'd0, done, pass}, 64'd1);
    store(32'h48, 32'h55);
    tick();
    idle_bus();
    rd_ready = 1'b1;
    tick();
    check("drain_empty", {62'd0, rd_valid, done}, 64'd0);
    tick();
    check("done_pass", {62'd0, done, pass}, 64'd3);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("done_holds", {62'd0, start, done}, 64'd1);

    // Failing verdict.
    new_run();
    store(32'h64, 32'h5);
    tick();
    idle_bus();
    tick();
    tick();
    check("fail_verdict", {60'd0, done, pass, overflow, timeout}, 64'h8);

    // Reset during DRAIN discards the queue.
    new_run();
    rd_ready = 1'b0;
    store(32'h64, 32'h7);
    tick();
    idle_bus();
    check("pre_abort_valid", {63'd0, rd_valid}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_state", {60'd0, rd_valid, start, done, pass}, 64'd0);

    // TIMEOUT=16: start high for exactly 16 cycles.
    new_run();
    for (int c = 0; c < 15; c++) tick();
    check("to_last_run", {62'd0, start_t, timeout_t}, 64'd2);
    tick();
    check("to_fire", {61'd0, start_t, timeout_t, pass_t}, 64'd2);
    tick();
    check("to_done", {61'd0, done_t, timeout_t, pass_t}, 64'd6);

    // Done store on the final counted cycle wins over timeout.
    new_run();
    for (int c = 0; c < 15; c++) tick();
    store(32'h64, 32'h7);
    tick();
    idle_bus();
    check("to_tie", {61'd0, start_t, timeout_t, pass_t}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
